fixed_order_selector: RTL and testbench

FIXED_ORDER_SELECTOR -- requirements
Module: fixed_order_selector

---
 rtl/fixed_order_selector.sv | 181 ++++++++++++++++++
 tb/tb_fixed_order_selector.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_order_selector.sv
// fixed_order_selector
//   Evaluates the fixed polynomial predictors of order 0..MAX_ORDER on a
//   block of PCM samples. For each order it sums the absolute residuals over
//   the block. After the last sample of a block it reports the order with the
//   smallest sum; on a tie the lowest order wins.
//
// Ports
//   iClock       sole clock, rising edge
//   iReset_n     asynchronous active-low reset
//   iEnable      sample qualifier; iSample is taken on an edge where it is 1
//   iSample      signed PCM sample, SAMPLE_W bits
//   oBest        chosen predictor order, 0..MAX_ORDER
//   oBestSum     sum of absolute residuals belonging to oBest
//   oValid       one-cycle pulse qualifying oBest/oBestSum
//   oBlockStart  1 while the next accepted sample is index 0 of a block
module fixed_order_selector #(
  parameter int  SAMPLE_W   = 16,
  parameter int  BLOCK_SIZE = 4096,
  parameter int  MAX_ORDER  = 4,
  localparam int RES_W      = SAMPLE_W + MAX_ORDER,
  localparam int IDX_W      = $clog2(BLOCK_SIZE),
  localparam int SUM_W      = RES_W + IDX_W
) (
  input  logic                       iClock,
  input  logic                       iReset_n,
  input  logic                       iEnable,
  input  logic signed [SAMPLE_W-1:0] iSample,
  output logic [2:0]                 oBest,
  output logic [SUM_W-1:0]           oBestSum,
  output logic                       oValid,
  output logic                       oBlockStart
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);

  // Sample index within the current block and the difference history.
  // hist_r[k] is the previous value of residual e_k.
  logic [IDX_W-1:0]        idx_r;
  logic signed [RES_W-1:0] hist_r [0:MAX_ORDER-1];
  logic signed [RES_W-1:0] res_s  [0:MAX_ORDER];

  // Stage 1: masked absolute residuals plus block position flags.
  logic [RES_W-1:0] abs1_r [0:MAX_ORDER];
  logic             v1_r;
  logic             first1_r;
  logic             last1_r;

  // Stage 2: running sums; done2_r marks that the sums are final.
  logic [SUM_W-1:0] acc_r [0:MAX_ORDER];
  logic             done2_r;

  // Compare stage: frozen copy of the finished block's sums, so the next
  // block may start accumulating immediately.
  logic [SUM_W-1:0] snap_r [0:MAX_ORDER];
  logic             v3_r;

  logic [2:0]       best_s;
  logic [SUM_W-1:0] best_sum_s;

  // |v| fits in RES_W unsigned bits, including the most negative value.
  function automatic logic [RES_W-1:0] abs_res(input logic signed [RES_W-1:0] v);
    if (v[RES_W-1]) begin
      return RES_W'(-v);
    end else begin
      return RES_W'(v);
    end
  endfunction

  // Residual chain: e0 = x, ek = e(k-1) - previous e(k-1), full width.
  always_comb begin
    res_s[0] = {{MAX_ORDER{iSample[SAMPLE_W-1]}}, iSample};
    for (int k = 1; k <= MAX_ORDER; k++) begin
      res_s[k] = res_s[k-1] - hist_r[k-1];
    end
  end

  // Block index counter and difference history; both hold during gaps and
  // the history deliberately carries across block boundaries.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      idx_r <= {IDX_W{1'b0}};
      for (int k = 0; k < MAX_ORDER; k++) begin
        hist_r[k] <= {RES_W{1'b0}};
      end
    end else if (iEnable) begin
      idx_r <= (idx_r == LAST_IDX) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
      for (int k = 0; k < MAX_ORDER; k++) begin
        hist_r[k] <= res_s[k];
      end
    end
  end

  // Stage 1: order k ignores the first k samples of a block, whose residual
  // would otherwise reach back into the previous block.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      v1_r     <= 1'b0;
      first1_r <= 1'b0;
      last1_r  <= 1'b0;
      for (int k = 0; k <= MAX_ORDER; k++) begin
        abs1_r[k] <= {RES_W{1'b0}};
      end
    end else begin
      v1_r <= iEnable;
      if (iEnable) begin
        first1_r <= (idx_r == {IDX_W{1'b0}});
        last1_r  <= (idx_r == LAST_IDX);
        for (int k = 0; k <= MAX_ORDER; k++) begin
          abs1_r[k] <= (idx_r < IDX_W'(k)) ? {RES_W{1'b0}} : abs_res(res_s[k]);
        end
      end
    end
  end

  // Stage 2: accumulate; the first sample of a block restarts each sum.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      done2_r <= 1'b0;
      for (int k = 0; k <= MAX_ORDER; k++) begin
        acc_r[k] <= {SUM_W{1'b0}};
      end
    end else begin
      done2_r <= v1_r & last1_r;
      if (v1_r) begin
        for (int k = 0; k <= MAX_ORDER; k++) begin
          acc_r[k] <= (first1_r ? {SUM_W{1'b0}} : acc_r[k]) + SUM_W'(abs1_r[k]);
        end
      end
    end
  end

  // Snapshot of the finished sums into the compare stage.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      v3_r <= 1'b0;
      for (int k = 0; k <= MAX_ORDER; k++) begin
        snap_r[k] <= {SUM_W{1'b0}};
      end
    end else begin
      v3_r <= done2_r;
      if (done2_r) begin
        for (int k = 0; k <= MAX_ORDER; k++) begin
          snap_r[k] <= acc_r[k];
        end
      end
    end
  end

  // Minimum search; strict less-than keeps the lowest order on ties.
  always_comb begin
    best_s     = 3'd0;
    best_sum_s = snap_r[0];
    for (int k = 1; k <= MAX_ORDER; k++) begin
      if (snap_r[k] < best_sum_s) begin
        best_s     = 3'(k);
        best_sum_s = snap_r[k];
      end else begin
        best_s     = best_s;
        best_sum_s = best_sum_s;
      end
    end
  end

  // Registered result; held until the next block completes.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      oValid   <= 1'b0;
      oBest    <= 3'd0;
      oBestSum <= {SUM_W{1'b0}};
    end else begin
      oValid <= v3_r;
      if (v3_r) begin
        oBest    <= best_s;
        oBestSum <= best_sum_s;
      end
    end
  end

  assign oBlockStart = (idx_r == {IDX_W{1'b0}});

endmodule

// File: tb/tb_fixed_order_selector.sv
// Directed bench for fixed_order_selector with BLOCK_SIZE=16, MAX_ORDER=4.
module tb_fixed_order_selector;

  localparam int SAMPLE_W   = 16;
  localparam int BLOCK_SIZE = 16;
  localparam int MAX_ORDER  = 4;
  localparam int SUM_W      = SAMPLE_W + MAX_ORDER + 4;

  logic                       iClock   = 1'b0;
  logic                       iReset_n = 1'b0;
  logic                       iEnable  = 1'b0;
  logic signed [SAMPLE_W-1:0] iSample  = '0;
  logic [2:0]                 oBest;
  logic [SUM_W-1:0]           oBestSum;
  logic                       oValid;
  logic                       oBlockStart;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 iClock = ~iClock;

  fixed_order_selector #(
    .SAMPLE_W  (SAMPLE_W),
    .BLOCK_SIZE(BLOCK_SIZE),
    .MAX_ORDER (MAX_ORDER)
  ) dut (
    .iClock     (iClock),
    .iReset_n   (iReset_n),
    .iEnable    (iEnable),
    .iSample    (iSample),
    .oBest      (oBest),
    .oBestSum   (oBestSum),
    .oValid     (oValid),
    .oBlockStart(oBlockStart)
  );

  // Event log: edge numbers of accepted last samples and of oValid pulses.
  int               cyc    = 0;
  int               tb_idx = 0;
  int               last_cyc   [$];
  int               pulse_cyc  [$];
  logic [2:0]       pulse_best [$];
  logic [SUM_W-1:0] pulse_sum  [$];

  always begin
    @(posedge iClock);
    #1;
    cyc++;
    if (!iReset_n) begin
      tb_idx = 0;
    end else if (iEnable) begin
      if (tb_idx == BLOCK_SIZE - 1) begin
        last_cyc.push_back(cyc);
        tb_idx = 0;
      end else begin
        tb_idx++;
      end
    end
    if (oValid) begin
      pulse_cyc.push_back(cyc);
      pulse_best.push_back(oBest);
      pulse_sum.push_back(oBestSum);
    end
  end

  function automatic logic signed [SAMPLE_W-1:0] gen(input int kind, input int i);
    case (kind)
      0:       return 16'sd1000;
      1:       return SAMPLE_W'(i);
      2:       return SAMPLE_W'(i * i);
      3:       return SAMPLE_W'(i * i * i);
      4:       return (i % 2 == 0) ? 16'sd32767 : -16'sd32767;
      default: return 16'sd0;
    endcase
  endfunction

  task automatic clear_logs();
    last_cyc.delete();
    pulse_cyc.delete();
    pulse_best.delete();
    pulse_sum.delete();
  endtask

  // Drives samples first..BLOCK_SIZE-1 of a pattern, optionally with gaps.
  task automatic drive_samples(input int kind, input int first, input bit gaps);
    for (int i = first; i < BLOCK_SIZE; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 2);
        repeat (g) begin
          @(negedge iClock);
          iEnable = 1'b0;
          iSample = 16'sd0;
        end
      end
      @(negedge iClock);
      iEnable = 1'b1;
      iSample = gen(kind, i);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iClock);
      iEnable = 1'b0;
    end
  endtask

  task automatic test_reset();
    iReset_n = 1'b0;
    repeat (2) @(negedge iClock);
    n_checks++;
    if (oValid !== 1'b0 || oBest !== 3'd0 || oBestSum !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%0b best=%0d sum=%0d, required 0/0/0", oValid, oBest, oBestSum);
    end
    n_checks++;
    if (oBlockStart !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_blockstart: got %0b, required 1", oBlockStart);
    end
    iReset_n = 1'b1;
    @(negedge iClock);
    n_checks++;
    if (oBlockStart !== 1'b1) begin
      n_fail++;
      $display("FAIL release_blockstart: got %0b, required 1", oBlockStart);
    end
  endtask

  task automatic test_constant();
    clear_logs();
    drive_samples(0, 0, 1'b0);
    idle(6);
    n_checks++;
    if (pulse_cyc.size() !== 1 || last_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL const_pulses: got %0d pulses, required 1", pulse_cyc.size());
    end else begin
      n_checks++;
      if (pulse_cyc[0] - last_cyc[0] !== 3) begin
        n_fail++;
        $display("FAIL const_latency: got %0d edges, required 3", pulse_cyc[0] - last_cyc[0]);
      end
      n_checks++;
      if (pulse_best[0] !== 3'd1 || pulse_sum[0] !== '0) begin
        n_fail++;
        $display("FAIL const_result: best=%0d sum=%0d, required 1/0", pulse_best[0], pulse_sum[0]);
      end
    end
    idle(4);
    n_checks++;
    if (oBest !== 3'd1 || oBestSum !== '0 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL const_hold: best=%0d sum=%0d valid=%0b, required 1/0/0", oBest, oBestSum, oValid);
    end
  endtask

  task automatic test_patterns();
    int kinds   [5] = '{1, 2, 3, 4, 5};
    int ex_best [5] = '{2, 3, 4, 0, 0};
    int ex_sum  [5] = '{0, 0, 0, 524272, 0};
    for (int p = 0; p < 5; p++) begin
      clear_logs();
      drive_samples(kinds[p], 0, 1'b0);
      idle(6);
      n_checks++;
      if (pulse_cyc.size() !== 1 || last_cyc.size() !== 1) begin
        n_fail++;
        $display("FAIL pattern%0d_pulses: got %0d pulses, required 1", kinds[p], pulse_cyc.size());
      end else begin
        n_checks++;
        if (pulse_cyc[0] - last_cyc[0] !== 3) begin
          n_fail++;
          $display("FAIL pattern%0d_latency: got %0d edges, required 3", kinds[p], pulse_cyc[0] - last_cyc[0]);
        end
        n_checks++;
        if (int'(pulse_best[0]) !== ex_best[p] || int'(pulse_sum[0]) !== ex_sum[p]) begin
          n_fail++;
          $display("FAIL pattern%0d_result: best=%0d sum=%0d, required %0d/%0d",
                   kinds[p], pulse_best[0], pulse_sum[0], ex_best[p], ex_sum[p]);
        end
      end
    end
  endtask

  task automatic test_block_start();
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      @(negedge iClock);
      iEnable = 1'b1;
      iSample = gen(1, i);
    end
    @(negedge iClock);
    iEnable = 1'b0;
    n_checks++;
    if (oBlockStart !== 1'b0) begin
      n_fail++;
      $display("FAIL midblock_blockstart: got %0b, required 0", oBlockStart);
    end
    drive_samples(1, 5, 1'b0);
    idle(6);
    n_checks++;
    if (oBlockStart !== 1'b1) begin
      n_fail++;
      $display("FAIL endblock_blockstart: got %0b, required 1", oBlockStart);
    end
    n_checks++;
    if (pulse_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL split_pulses: got %0d pulses, required 1", pulse_cyc.size());
    end else begin
      n_checks++;
      if (pulse_best[0] !== 3'd2 || pulse_sum[0] !== '0) begin
        n_fail++;
        $display("FAIL split_result: best=%0d sum=%0d, required 2/0", pulse_best[0], pulse_sum[0]);
      end
    end
  endtask

  task automatic test_back_to_back(input bit gaps);
    clear_logs();
    drive_samples(1, 0, gaps);
    drive_samples(0, 0, gaps);
    idle(8);
    n_checks++;
    if (pulse_cyc.size() !== 2 || last_cyc.size() !== 2) begin
      n_fail++;
      $display("FAIL b2b_gaps%0b_pulses: got %0d pulses, required 2", gaps, pulse_cyc.size());
    end else begin
      for (int b = 0; b < 2; b++) begin
        n_checks++;
        if (pulse_cyc[b] - last_cyc[b] !== 3) begin
          n_fail++;
          $display("FAIL b2b_gaps%0b_latency%0d: got %0d edges, required 3", gaps, b, pulse_cyc[b] - last_cyc[b]);
        end
      end
      n_checks++;
      if (pulse_best[0] !== 3'd2 || pulse_best[1] !== 3'd1 || pulse_sum[0] !== '0 || pulse_sum[1] !== '0) begin
        n_fail++;
        $display("FAIL b2b_gaps%0b_result: best=%0d,%0d sum=%0d,%0d, required 2,1 0,0",
                 gaps, pulse_best[0], pulse_best[1], pulse_sum[0], pulse_sum[1]);
      end
    end
  endtask

  task automatic test_reset_in_flight();
    clear_logs();
    drive_samples(1, 0, 1'b0);
    @(negedge iClock);
    iEnable  = 1'b0;
    iReset_n = 1'b0;
    @(negedge iClock);
    iReset_n = 1'b1;
    idle(6);
    n_checks++;
    if (pulse_cyc.size() !== 0) begin
      n_fail++;
      $display("FAIL inflight_pulses: got %0d pulses, required 0", pulse_cyc.size());
    end
  endtask

  task automatic test_reset_mid_block();
    clear_logs();
    for (int i = 0; i < 9; i++) begin
      @(negedge iClock);
      iEnable = 1'b1;
      iSample = gen(1, i);
    end
    @(negedge iClock);
    iEnable  = 1'b0;
    iReset_n = 1'b0;
    #1;
    n_checks++;
    if (oBlockStart !== 1'b1 || oValid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_state: blockstart=%0b valid=%0b, required 1/0", oBlockStart, oValid);
    end
    @(negedge iClock);
    iReset_n = 1'b1;
    n_checks++;
    if (oBlockStart !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_release: blockstart=%0b, required 1", oBlockStart);
    end
    drive_samples(1, 0, 1'b0);
    idle(8);
    n_checks++;
    if (pulse_cyc.size() !== 1 || last_cyc.size() !== 1) begin
      n_fail++;
      $display("FAIL midreset_pulses: got %0d pulses, required 1", pulse_cyc.size());
    end else begin
      n_checks++;
      if (pulse_cyc[0] - last_cyc[0] !== 3 || pulse_best[0] !== 3'd2 || pulse_sum[0] !== '0) begin
        n_fail++;
        $display("FAIL midreset_result: latency=%0d best=%0d sum=%0d, required 3/2/0",
                 pulse_cyc[0] - last_cyc[0], pulse_best[0], pulse_sum[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_patterns();
    test_block_start();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_in_flight();
    test_reset_mid_block();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
